// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch/issue front end and the decode stage:
// opcode values, instruction field positions and the issue FSM encoding.
package isa_pkg;

  localparam int INSTR_BITS = 16;

  localparam logic [3:0] OP_RTYPE     = 4'b0000;
  localparam logic [3:0] OP_UNUSED_LO = 4'b1010;
  localparam logic [3:0] OP_UNUSED_HI = 4'b1110;
  localparam logic [3:0] OP_HALT      = 4'b1111;

  // Least-significant bit of each field inside the 16-bit word
  localparam int OPC_LSB  = 12;
  localparam int RS_LSB   = 9;
  localparam int RT_LSB   = 6;
  localparam int RD_LSB   = 3;
  localparam int FUNC_LSB = 0;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  function automatic logic is_halt(input logic [3:0] opc);
    return opc == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational slicer: one 16-bit instruction word into its decode fields.
module instr_field_split
  import isa_pkg::*;
(
  input  logic [INSTR_BITS-1:0] instr,
  output logic [3:0]            opCode,
  output logic [2:0]            func,
  output logic [2:0]            rs,
  output logic [2:0]            rt,
  output logic [2:0]            rd,
  output logic [5:0]            imm
);

  assign opCode = instr[OPC_LSB  +: 4];
  assign rs     = instr[RS_LSB   +: 3];
  assign rt     = instr[RT_LSB   +: 3];
  assign rd     = instr[RD_LSB   +: 3];
  assign func   = instr[FUNC_LSB +: 3];
  assign imm    = instr[IMM_LSB  +: 6];

endmodule

// File: rtl/instr_issue_unit.sv
// Fetch/issue front end: fetches one word at a time over req/ack, holds it on a
// valid/ready issue port for decode, and redirects on taken branches.
module instr_issue_unit
  import isa_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [3:0]         opCode,
  output logic [2:0]         func,
  output logic [2:0]         rs,
  output logic [2:0]         rt,
  output logic [2:0]         rd,
  output logic [5:0]         imm,
  output logic [ADDR_W-1:0]  issue_pc,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               halted
);

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic                discard;
  logic [INSTR_W-1:0]  instr_p0;

  // Fetch/issue FSM with pc, discard flag and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RST;
      pc          <= RESET_PC;
      discard     <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      issue_valid <= 1'b0;
      instr_p0    <= '0;
      issue_pc    <= '0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_RST: begin
          // An ack still in flight from before reset must not be issued
          state     <= S_FETCH;
          discard   <= 1'b1;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        S_FETCH: begin
          if (branch_taken) begin
            pc <= branch_target;
            if (imem_ack) begin
              // Request completed this cycle; its word is dropped, ask for the target next
              discard   <= 1'b0;
              imem_addr <= branch_target;
            end else begin
              // Request stays outstanding; its eventual word must be dropped
              discard   <= 1'b1;
            end
          end else if (imem_ack) begin
            if (discard) begin
              discard   <= 1'b0;
              imem_addr <= pc;
            end else begin
              instr_p0    <= imem_rdata;
              issue_pc    <= pc;
              pc          <= pc + ADDR_W'(1);
              imem_addr   <= pc + ADDR_W'(1);
              imem_req    <= 1'b0;
              issue_valid <= 1'b1;
              state       <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (branch_taken) begin
            // Branch kills the held instruction even if decode is accepting it
            issue_valid <= 1'b0;
            pc          <= branch_target;
            imem_addr   <= branch_target;
            imem_req    <= 1'b1;
            state       <= S_FETCH;
          end else if (issue_ready) begin
            issue_valid <= 1'b0;
            if (is_halt(opCode)) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              imem_addr <= pc;
              imem_req  <= 1'b1;
              state     <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          imem_req    <= 1'b0;
          issue_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: state <= S_RST;
      endcase
    end
  end

  instr_field_split u_split (
    .instr  (instr_p0),
    .opCode (opCode),
    .func   (func),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .imm    (imm)
  );

endmodule
